// File: rtl/alu64bit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu64bit_pkg
// Purpose  : Shared op/state encodings and the golden ALU function.
// Revision : 1.0 - initial release
// ============================================================================
package alu64bit_pkg;

  localparam int ALU_MAX_W = 64;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    REPORT = 2'b10
  } chk_state_t;

  // Returns {cout, s}; the result is confined to the low w bits and cout is
  // taken from bit w, so narrower checkers share the same reference.
  function automatic logic [ALU_MAX_W:0] alu_ref(
    input logic [ALU_MAX_W-1:0] a,
    input logic [ALU_MAX_W-1:0] b,
    input logic                 cin,
    input alu_op_t              op,
    input logic [6:0]           w
  );
    logic [ALU_MAX_W:0] c_one;
    logic [ALU_MAX_W:0] mask;
    logic [ALU_MAX_W:0] sum;
    logic               cout;
    c_one = {{ALU_MAX_W{1'b0}}, 1'b1};
    mask  = (c_one << w) - c_one;
    sum   = '0;
    cout  = 1'b0;
    case (op)
      OP_NOR: sum = {1'b0, ~(a | b)};
      OP_XOR: sum = {1'b0, a ^ b};
      OP_ADD: begin
        sum  = {1'b0, a} + {1'b0, b} + {{ALU_MAX_W{1'b0}}, cin};
        cout = sum[w];
      end
      OP_SUB: begin
        sum  = {1'b0, a} + {1'b0, ~b & mask[ALU_MAX_W-1:0]} + {{ALU_MAX_W{1'b0}}, cin};
        cout = sum[w];
      end
      default: sum = '0;
    endcase
    return {cout, sum[ALU_MAX_W-1:0] & mask[ALU_MAX_W-1:0]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu64bit_ref_model.sv
`default_nettype none
// ============================================================================
// Module   : alu64bit_ref_model
// Purpose  : Combinational golden model of the gate-level ALU.
// Revision : 1.0 - initial release
// ============================================================================
module alu64bit_ref_model
  import alu64bit_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [ALU_MAX_W-1:0] w_a;
  logic [ALU_MAX_W-1:0] w_b;
  logic [ALU_MAX_W:0]   w_res;

  generate
    if (WIDTH == ALU_MAX_W) begin : g_full
      assign w_a = a;
      assign w_b = b;
    end else begin : g_ext
      assign w_a = {{(ALU_MAX_W-WIDTH){1'b0}}, a};
      assign w_b = {{(ALU_MAX_W-WIDTH){1'b0}}, b};
    end
  endgenerate

  assign w_res = alu_ref(w_a, w_b, cin, op, 7'(WIDTH));
  assign s     = w_res[WIDTH-1:0];
  assign cout  = w_res[ALU_MAX_W];

endmodule
`default_nettype wire

// File: rtl/alu64bit_checker.sv
`default_nettype none
// ============================================================================
// Module   : alu64bit_checker
// Purpose  : Self-checking response monitor for the 64-bit gate-level ALU.
// Revision : 1.0 - initial release
// ============================================================================
module alu64bit_checker
  import alu64bit_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int SETTLE = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dut_s,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             match,
  output logic [WIDTH-1:0] exp_s,
  output logic             exp_cout,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [7:0]       c_settle_load = 8'(SETTLE - 1);
  localparam logic [CNT_W-1:0] c_cnt_max     = '1;

  chk_state_t       r_state;
  logic [7:0]       r_settle;
  logic             r_busy;
  logic             r_done;
  logic             r_match;
  logic [WIDTH-1:0] r_exp_s;
  logic             r_exp_cout;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_err;

  logic [WIDTH-1:0] w_ref_s;
  logic             w_ref_cout;
  logic             w_match;

  // The model sees the operands on the capture edge, so exp_s is valid from
  // the first busy cycle onward.
  alu64bit_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .op   (alu_op_t'(op)),
    .s    (w_ref_s),
    .cout (w_ref_cout)
  );

  // Case equality makes X/Z on the ALU outputs a mismatch in simulation.
  assign w_match = (dut_s === r_exp_s) && (dut_cout === r_exp_cout);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_settle   <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_match    <= 1'b0;
      r_exp_s    <= '0;
      r_exp_cout <= 1'b0;
      r_pass     <= '0;
      r_err      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_exp_s    <= w_ref_s;
            r_exp_cout <= w_ref_cout;
            r_settle   <= c_settle_load;
            r_busy     <= 1'b1;
            r_state    <= WAIT;
          end
        end
        WAIT: begin
          if (r_settle == 8'd0) begin
            r_match <= w_match;
            if (w_match) begin
              if (r_pass != c_cnt_max) r_pass <= r_pass + 1'b1;
            end else begin
              if (r_err != c_cnt_max) r_err <= r_err + 1'b1;
            end
            r_done  <= 1'b1;
            r_state <= REPORT;
          end else begin
            r_settle <= r_settle - 8'd1;
          end
        end
        REPORT: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign match      = r_match;
  assign exp_s      = r_exp_s;
  assign exp_cout   = r_exp_cout;
  assign pass_count = r_pass;
  assign err_count  = r_err;

endmodule
`default_nettype wire

// File: doc/alu64bit_checker.md
Name: alu64bit_checker

Overview:
- Synchronous self-checking monitor that sits on the response side of the 64-bit gate-level ALU.
- Accepts one stimulus vector per transaction (a, b, cin, op) and computes the golden result.
- Waits a programmable settle time for the ripple/lookahead gate delays, samples the ALU outputs, then compares them and reports.
- Keeps running pass/error totals, so benches and FPGA smoke tests get a single verdict instead of waveform inspection.

Parameters:
- WIDTH, 64, operand/result width; must match the ALU under check.
- SETTLE, 8, clock cycles from stimulus capture to sampling of dut_s/dut_cout; legal range 1..255.
- CNT_W, 16, width of the pass and error counters.

Ports:
- clk  input  1  single clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to check the vector on a/b/cin/op this cycle.
- a  input  WIDTH  operand A, captured on start.
- b  input  WIDTH  operand B, captured on start.
- cin  input  1  carry-in, captured on start.
- op  input  2  operation, captured on start.
- dut_s  input  WIDTH  ALU result under check.
- dut_cout  input  1  ALU carry-out under check.
- busy  output  1  transaction in progress; start is ignored while high.
- done  output  1  one-cycle pulse when the verdict is valid.
- match  output  1  verdict: 1 means s and cout both equal the expected values; held until the next done.
- exp_s  output  WIDTH  registered expected result.
- exp_cout  output  1  registered expected carry.
- pass_count  output  CNT_W  matching transactions; saturating.
- err_count  output  CNT_W  mismatching transactions; saturating.

Behaviour:
- Reset (asynchronous, any time, including mid-transaction):
  - state=IDLE; busy, done, match = 0.
  - exp_s = 0, exp_cout = 0.
  - Both counters = 0; the settle counter is cleared.
- Op encoding (fixed team definition):
  - 00: s = ~(a|b), cout = 0.
  - 01: s = a^b, cout = 0.
  - 10: {cout,s} = a + b + cin.
  - 11: {cout,s} = a + ~b + cin (subtract when cin=1).
  - Arithmetic is done at WIDTH+1 bits; cout is bit WIDTH.
- FSM states IDLE, WAIT, REPORT:
  - IDLE, start=1 at edge k: capture the operands, register exp_s/exp_cout, load the settle counter with SETTLE-1, go to WAIT. busy=1 from k+1.
  - IDLE, start=0: stay.
  - WAIT: the counter decrements each edge. At the edge where the counter is 0, sample dut_s/dut_cout and register match, update exactly one counter, go to REPORT.
  - REPORT: done=1 and busy=1 for exactly one cycle. Next edge goes to IDLE.
  - Result: done is high during cycle k+SETTLE+1. A start in that same cycle is not accepted; the earliest accepted next start is at edge k+SETTLE+2.
- start while busy: ignored, with no queuing and no error.
- SETTLE=1: WAIT lasts one cycle.
- Counters saturate at all-ones; a saturated counter does not wrap, and the other counter still increments.
- match, exp_s and exp_cout hold their values between transactions.
- X/Z on dut_s is counted as a mismatch (compare with !==-equivalent semantics in simulation; synthesis uses ==).

Decomposition:
- Shared package alu64bit_pkg holds:
  - typedef enum logic [1:0] alu_op_t: OP_NOR=2'b00, OP_XOR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11.
  - typedef enum chk_state_t: IDLE, WAIT, REPORT.
  - A function alu_ref(a, b, cin, op) returning {cout, s}.
- One sub-module, alu64bit_ref_model: a purely combinational golden model wrapping alu_ref. The checker instantiates it on the captured operands.

Test Plan:
1. ADD basic: op=10, a=5, b=3, cin=0, correct ALU -> done at cycle k+9 (SETTLE=8), exp_s=8, exp_cout=0, match=1, pass_count=1.
2. ADD overflow: op=10, a=64'hFFFF_FFFF_FFFF_FFFF, b=1, cin=0 -> exp_s=0, exp_cout=1, match=1.
3. SUB: op=11, cin=1, a=5, b=3 -> exp_s=2, exp_cout=1. Then a=3, b=5 -> exp_s=64'hFFFF_FFFF_FFFF_FFFE, exp_cout=0. Both match=1.
4. Logic ops and fault: op=00, a=b=0 -> exp_s=all ones. Force dut_s bit 17 wrong -> match=0, err_count=1, pass_count unchanged.
5. Handshake: pulse start again on busy cycles k+1..k+9 -> ignored, exactly one done. Start at k+10 is accepted.
6. Reset mid-WAIT at cycle k+4: all outputs zero immediately, no done pulse. Set CNT_W=2 and run 5 passing vectors -> pass_count saturates at 3.
